fp_mult_core: RTL and testbench
===============================

FP_MULT_CORE -- requirements
Module: fp_mult_core

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (rising edge), rst_n.
REQ-002 Ports, one per line:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  core can accept operands
- ma_a  input  16  operand A mantissa, two's complement
- ea_a  input  8  operand A exponent, two's complement
- ma_b  input  16  operand B mantissa, two's complement
- ea_b  input  8  operand B exponent, two's complement
- out_valid  output  1  product valid
- out_ready  input  1  downstream (justify stage) accepts product
- ma  output  30  product magnitude, unsigned
- ea  output  10  exponent sum, two's complement
- sign  output  1  product sign
- busy  output  1  state != IDLE
- sat  output  1  an operand equal to 16'h8000 was clamped (valid with out_valid)

Function
REQ-003 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); busy = !in_ready.
REQ-004 Accept on the rising edge where in_valid & in_ready: register |ma_a|, |ma_b| as 15-bit magnitudes, sign = ma_a[15]^ma_b[15], ea = sext10(ea_a)+sext10(ea_b).
REQ-005 A magnitude of 16'h8000 SHALL be clamped to 15'h7FFF, with sat set to 1 for that operation.
REQ-006 If either mantissa is zero at accept: skip CALC, go to DONE; ma=0, ea=0, sign=0, sat=0; out_valid rises on the next rising edge.
REQ-007 CALC SHALL perform unsigned shift-add of the two 15-bit magnitudes, 1 multiplier bit per cycle, with an iteration counter.
- The 15th CALC edge writes the final 30-bit ma and moves to DONE with out_valid=1.
- Latency: out_valid is high 16 edges after the accepting edge (accept edge + 15 CALC edges).
REQ-008 ma SHALL equal exactly |A|*|B| (max 15'h7FFF^2 = 30'h3FFF0001); no rounding and no truncation.
REQ-009 In DONE: out_valid=1 and ma/ea/sign/sat held stable until out_valid & out_ready; on that edge go to IDLE with out_valid=0.
REQ-010 No new operand is accepted in CALC or DONE; in_ready is low there. in_valid asserted there is ignored and not queued.
REQ-011 In IDLE with in_valid=0, the FSM remains IDLE and outputs hold their last values, except out_valid=0.
REQ-012 ea SHALL NOT saturate or wrap: range is -256..254 in 10 bits; overflow/underflow detection belongs downstream.
REQ-013 out_ready is ignored in IDLE and CALC.

Reset
REQ-014 rst_n low SHALL asynchronously force: state=IDLE, counter=0, ma=0, ea=0, sign=0, sat=0, out_valid=0, busy=0, and in_ready=0 while rst_n is low.
REQ-015 Reset asserted during CALC or DONE SHALL discard the operation; after release, in_ready=1 on the first clock edge.

Configuration
REQ-016 With macro FP_MULT_RADIX4_EN defined:
- CALC SHALL process 2 multiplier bits per cycle (multiplier zero-extended to 16 bits).
- CALC takes 8 cycles; out_valid is high 9 edges after the accepting edge.
REQ-017 Without FP_MULT_RADIX4_EN, radix-2 behaviour applies (15 CALC cycles). Results SHALL be bit-identical in both builds.

Verification
REQ-018 ma_a=16'h4000, ea_a=8'h02, ma_b=16'h4000, ea_b=8'hFF -> ma=30'h10000000, ea=10'h001, sign=0, sat=0, out_valid at edge 16 (edge 9 with FP_MULT_RADIX4_EN).
REQ-019 ma_a=16'hC000 (-0x4000), ma_b=16'h7FFF, ea_a=ea_b=8'h80 -> ma=30'h1FFFC000, sign=1, ea=10'h300.
REQ-020 ma_a=16'h8000, ma_b=16'h8000 -> ma=30'h3FFF0001, sign=0, sat=1.
REQ-021 ma_a=0, ma_b=16'h1234 -> out_valid on the edge after accept; ma=0, ea=0, sign=0.
REQ-022 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge; a back-to-back in_valid is accepted only then.
REQ-023 rst_n pulsed low mid-CALC -> immediate IDLE with all outputs zero; the next operation completes correctly.

Source files
------------

// File: rtl/fp_mult_core.sv
// fp_mult_core: sequential mantissa multiplier for a signed-magnitude FP datapath.
// Accepts two's-complement 16-bit mantissas and 8-bit exponents. It produces the
// exact unsigned 30-bit magnitude product, the product sign and the 10-bit
// exponent sum. The downstream justify stage normalises and detects exponent
// range errors.
// Build option: define FP_MULT_RADIX4_EN to retire two multiplier bits per CALC
// cycle (8 cycles) instead of one (15 cycles). Results are identical either way.
module fp_mult_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ma_a,
    input  logic [7:0]  ea_a,
    input  logic [15:0] ma_b,
    input  logic [7:0]  ea_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] ma,
    output logic [9:0]  ea,
    output logic        sign,
    output logic        busy,
    output logic        sat
);

`ifdef FP_MULT_RADIX4_EN
    localparam int       STEP = 2;
    localparam logic [3:0] LAST = 4'd7;
`else
    localparam int       STEP = 1;
    localparam logic [3:0] LAST = 4'd14;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        armed;
    logic [3:0]  cnt;
    logic [29:0] acc;
    logic [29:0] mcand;
    logic [15:0] mplier;
    logic [29:0] pp;
    logic [29:0] acc_nxt;
    logic [14:0] mag_a, mag_b;
    logic        sat_a, sat_b;
    logic        zero_in;
    logic        accept;
    logic        last_step;
    logic [9:0]  ea_sum;

    // Magnitude of a two's-complement mantissa; -32768 has no 15-bit
    // magnitude, so it is clamped to the largest representable value.
    function automatic logic [14:0] clamp_mag(input logic [15:0] v);
        logic [15:0] m;
        m = v[15] ? (~v + 16'd1) : v;
        return m[15] ? 15'h7FFF : m[14:0];
    endfunction

    assign mag_a     = clamp_mag(ma_a);
    assign mag_b     = clamp_mag(ma_b);
    assign sat_a     = (ma_a == 16'h8000);
    assign sat_b     = (ma_b == 16'h8000);
    assign zero_in   = (ma_a == 16'd0) || (ma_b == 16'd0);
    assign ea_sum    = {{2{ea_a[7]}}, ea_a} + {{2{ea_b[7]}}, ea_b};
    // armed keeps in_ready low until the first clock edge after reset release.
    assign in_ready  = armed && (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == LAST);

    // Partial product for the current multiplier digit and the running sum.
    always_comb begin
        pp = '0;
        if (mplier[0]) pp = mcand;
`ifdef FP_MULT_RADIX4_EN
        if (mplier[1]) pp = pp + {mcand[28:0], 1'b0};
`endif
        acc_nxt = acc + pp;
    end

    // Next-state logic for the accept / iterate / hand-off sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_in ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, iteration counter and the result registers seen downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            cnt       <= 4'd0;
            ma        <= '0;
            ea        <= '0;
            sign      <= 1'b0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    cnt       <= 4'd0;
                    if (accept) begin
                        if (zero_in) begin
                            ma   <= '0;
                            ea   <= '0;
                            sign <= 1'b0;
                            sat  <= 1'b0;
                        end else begin
                            ea   <= ea_sum;
                            sign <= ma_a[15] ^ ma_b[15];
                            sat  <= sat_a || sat_b;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (last_step) begin
                        ma        <= acc_nxt;
                        out_valid <= 1'b1;
                        cnt       <= 4'd0;
                    end
                end
                DONE: begin
                    // The zero-operand path enters DONE with out_valid low and
                    // raises it one edge later.
                    out_valid <= !(out_valid && out_ready);
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

    // Shift-add datapath; loaded on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= '0;
            mcand  <= {15'd0, mag_a};
            mplier <= {1'b0, mag_b};
        end else if (state == CALC) begin
            acc    <= acc_nxt;
            mcand  <= mcand << STEP;
            mplier <= mplier >> STEP;
        end
    end

endmodule

// File: tb/tb_fp_mult_core.sv
// Directed testbench for fp_mult_core: table of operand pairs with hand-computed
// products, plus backpressure and mid-operation reset sequences.
module tb_fp_mult_core;

`ifdef FP_MULT_RADIX4_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ma_a, ma_b;
    logic [7:0]  ea_a, ea_b;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] ma;
    logic [9:0]  ea;
    logic        sign, busy, sat;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] ma_a;
        logic [7:0]  ea_a;
        logic [15:0] ma_b;
        logic [7:0]  ea_b;
        logic [29:0] exp_ma;
        logic [9:0]  exp_ea;
        logic        exp_sign;
        logic        exp_sat;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    fp_mult_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ma_a(ma_a), .ea_a(ea_a), .ma_b(ma_b), .ea_b(ea_b),
        .out_valid(out_valid), .out_ready(out_ready), .ma(ma), .ea(ea),
        .sign(sign), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        ma_a = v.ma_a; ea_a = v.ea_a; ma_b = v.ma_b; ea_b = v.ea_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(lat);
        chk({tag, " latency"}, lat, v.zero ? 32'd2 : LAT);
        chk({tag, " ma"},   {2'd0, ma}, {2'd0, v.exp_ma});
        chk({tag, " ea"},   {22'd0, ea}, {22'd0, v.exp_ea});
        chk({tag, " sign"}, {31'd0, sign}, {31'd0, v.exp_sign});
        chk({tag, " sat"},  {31'd0, sat}, {31'd0, v.exp_sat});
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " idle ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " ma held"}, {2'd0, ma}, {2'd0, v.exp_ma});
    endtask

    initial begin
        int lat;
        logic [29:0] hold_ma;
        logic [9:0]  hold_ea;

        vecs[0] = '{16'h4000, 8'h02, 16'h4000, 8'hFF, 30'h10000000, 10'h001, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hC000, 8'h80, 16'h7FFF, 8'h80, 30'h1FFFC000, 10'h300, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 8'h00, 16'h8000, 8'h00, 30'h3FFF0001, 10'h000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 8'h05, 16'h1234, 8'h03, 30'h0,        10'h000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 8'h7F, 16'h0000, 8'h7F, 30'h0,        10'h000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0001, 8'h7F, 16'h0001, 8'h7F, 30'h1,        10'h0FE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 8'h01, 16'h0003, 8'h02, 30'h3,        10'h003, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 8'h10, 16'h0002, 8'hF0, 30'hFFFE,     10'h000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 8'h7F, 16'h7FFF, 8'h7F, 30'h3FFF0001, 10'h0FE, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'hEDCC, 8'h81, 16'h5678, 8'h01, 30'h06260060, 10'h382, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ma_a = '0; ma_b = '0; ea_a = '0; ea_b = '0;

        // Reset state.
        #3;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst ma", {2'd0, ma}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release ready before edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("release ready after edge", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure with in_valid held high through CALC and DONE.
        @(negedge clk);
        ma_a = vecs[1].ma_a; ea_a = vecs[1].ea_a; ma_b = vecs[1].ma_b; ea_b = vecs[1].ea_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ma_a = vecs[8].ma_a; ea_a = vecs[8].ea_a; ma_b = vecs[8].ma_b; ea_b = vecs[8].ea_b;
        wait_out_valid(lat);
        chk("bp latency", lat, LAT);
        hold_ma = ma;
        hold_ea = ea;
        chk("bp ma", {2'd0, ma}, {2'd0, vecs[1].exp_ma});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp hold%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp hold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp hold%0d ma", c), {2'd0, ma}, {2'd0, hold_ma});
            chk($sformatf("bp hold%0d ea", c), {22'd0, ea}, {22'd0, hold_ea});
            chk($sformatf("bp hold%0d sign", c), {31'd0, sign}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp next accepted", {31'd0, busy}, 32'd1);
        wait_out_valid(lat);
        chk("bp next latency", lat, LAT);
        chk("bp next ma", {2'd0, ma}, {2'd0, vecs[8].exp_ma});
        chk("bp next ea", {22'd0, ea}, {22'd0, vecs[8].exp_ea});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulsed in the middle of CALC.
        ma_a = vecs[0].ma_a; ea_a = vecs[0].ea_a; ma_b = vecs[0].ma_b; ea_b = vecs[0].ea_b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midcalc busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst ma", {2'd0, ma}, 32'd0);
        chk("midrst ea", {22'd0, ea}, 32'd0);
        chk("midrst sat", {31'd0, sat}, 32'd0);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst ready after edge", {31'd0, in_ready}, 32'd1);
        run_op(vecs[9], "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
